// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states, bus constants and pointer helper for the I2C register target
package i2c_pkg;

  // One-hot state encoding
  typedef enum logic [10:0] {
    ST_IDLE     = 11'b000_0000_0001,
    ST_DEV_ADDR = 11'b000_0000_0010,
    ST_DEV_ACK  = 11'b000_0000_0100,
    ST_ADDR_HI  = 11'b000_0000_1000,
    ST_ADDR_LO  = 11'b000_0001_0000,
    ST_ADDR_ACK = 11'b000_0010_0000,
    ST_WR_DATA  = 11'b000_0100_0000,
    ST_WR_ACK   = 11'b000_1000_0000,
    ST_RD_DATA  = 11'b001_0000_0000,
    ST_RD_ACK   = 11'b010_0000_0000,
    ST_IGNORE   = 11'b100_0000_0000
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int                   BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 4'd7;

  // Pointer auto-increment: full 16-bit wrap, or 8-bit wrap with the upper byte held at zero
  function automatic logic [15:0] ptr_inc(input logic [15:0] ptr, input logic mode16);
    if (mode16) return ptr + 16'd1;
    else        return {8'h00, ptr[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - bus line synchroniser, optional glitch filter (GLITCH_FILTER_EN), edge strobes
module i2c_line_filter
`ifdef GLITCH_FILTER_EN
  #(parameter int FILT_LEN = 3)
`endif
(
  input  logic Clk,
  input  logic Rst_p,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1, r_sync2, r_prev, r_rise, r_fall;
  logic w_level;

  // Two-flop synchroniser; resets to the idle-high bus level so reset release makes no edge
  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one
  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(FILT_LEN - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Registered edge strobes; o_level is the delayed level so it lines up with the strobes
  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target bridging bus transfers to a byte-wide register file (GLITCH_FILTER_EN)
module i2c_slave_regs
  import i2c_pkg::*;
#(
`ifdef GLITCH_FILTER_EN
  parameter int FILT_LEN = 3,
`endif
  parameter int RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Rst_p,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  input  logic [7:0]  device_id,
  input  logic        addr_mode,
  output logic [15:0] reg_addr,
  output logic        wr_req,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        addr_nack
);

  // Countdown from rd_req so rd_data is captured exactly RD_LAT cycles later
  localparam logic [3:0] RD_CNT_LOAD = 4'(RD_LAT + 1);

  logic w_scl_lvl, w_scl_rise, w_scl_fall, w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_match;
  logic [7:0] w_byte;

  state_t                r_state, w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_lo_next, w_lo_next_nxt;
  logic                  r_wait_fall, w_wait_fall_nxt;
  logic [3:0]            r_rd_cnt, w_rd_cnt_nxt;
  logic                  r_sda_oe, w_sda_oe_nxt;
  logic [15:0]           r_reg_addr, w_reg_addr_nxt;
  logic [7:0]            r_wr_data, w_wr_data_nxt;
  logic                  r_wr_req, w_wr_req_nxt;
  logic                  r_rd_req, w_rd_req_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_addr_nack, w_addr_nack_nxt;

  i2c_line_filter
`ifdef GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_scl (.Clk(Clk), .Rst_p(Rst_p), .i_line(i2c_sclk),
         .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));

  i2c_line_filter
`ifdef GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_sda (.Clk(Clk), .Rst_p(Rst_p), .i_line(i2c_sdat),
         .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

  assign w_start      = w_scl_lvl & w_sda_fall;
  assign w_stop       = w_scl_lvl & w_sda_rise;
  assign w_byte       = {r_shift[6:0], w_sda_lvl};
  assign w_addr_match = ((w_byte ^ device_id) & 8'hFE) == 8'h00;

  // Open-drain: the driver register clears asynchronously on reset, releasing the line at once
  assign i2c_sdat  = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_addr  = r_reg_addr;
  assign wr_req    = r_wr_req;
  assign wr_data   = r_wr_data;
  assign rd_req    = r_rd_req;
  assign busy      = r_busy;
  assign addr_nack = r_addr_nack;

  // State and datapath registers
  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_lo_next   <= 1'b0;
      r_wait_fall <= 1'b0;
      r_rd_cnt    <= '0;
      r_sda_oe    <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_data   <= '0;
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_addr_nack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_lo_next   <= w_lo_next_nxt;
      r_wait_fall <= w_wait_fall_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_req    <= w_wr_req_nxt;
      r_rd_req    <= w_rd_req_nxt;
      r_busy      <= w_busy_nxt;
      r_addr_nack <= w_addr_nack_nxt;
    end
  end

  // Next-state logic: bytes are shifted in on SCL rise, SDA drive only changes after an SCL fall
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_lo_next_nxt   = r_lo_next;
    w_wait_fall_nxt = r_wait_fall;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_sda_oe_nxt    = r_sda_oe;
    w_reg_addr_nxt  = r_reg_addr;
    w_wr_data_nxt   = r_wr_data;
    w_wr_req_nxt    = 1'b0;
    w_rd_req_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    w_addr_nack_nxt = 1'b0;

    if (w_start) begin
      w_state_nxt   = ST_DEV_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_rd_cnt_nxt  = '0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_rd_cnt_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt != LAST_BIT) begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end else begin
              w_bit_cnt_nxt = '0;
              if (r_state == ST_DEV_ADDR) begin
                if (w_addr_match) begin
                  w_rw_nxt    = w_byte[0];
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = ST_DEV_ACK;
                end else begin
                  w_addr_nack_nxt = 1'b1;
                  w_state_nxt     = ST_IGNORE;
                end
              end else if (r_state == ST_ADDR_HI) begin
                w_reg_addr_nxt = {w_byte, r_reg_addr[7:0]};
                w_lo_next_nxt  = 1'b1;
                w_state_nxt    = ST_ADDR_ACK;
              end else if (r_state == ST_ADDR_LO) begin
                w_reg_addr_nxt = addr_mode ? {r_reg_addr[15:8], w_byte} : {8'h00, w_byte};
                w_lo_next_nxt  = 1'b0;
                w_state_nxt    = ST_ADDR_ACK;
              end else begin
                w_wr_data_nxt = w_byte;
                w_wr_req_nxt  = 1'b1;
                w_state_nxt   = ST_WR_ACK;
              end
            end
          end
        end
        ST_DEV_ACK, ST_ADDR_ACK, ST_WR_ACK: begin
          // First fall after the 8th bit starts driving ACK, the 9th fall ends it
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              if (r_state == ST_DEV_ACK) begin
                if (r_rw) begin
                  w_rd_req_nxt    = 1'b1;
                  w_rd_cnt_nxt    = RD_CNT_LOAD;
                  w_wait_fall_nxt = 1'b0;
                  w_state_nxt     = ST_RD_DATA;
                end else begin
                  w_state_nxt = addr_mode ? ST_ADDR_HI : ST_ADDR_LO;
                end
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = r_lo_next ? ST_ADDR_LO : ST_WR_DATA;
              end else begin
                w_reg_addr_nxt = ptr_inc(r_reg_addr, addr_mode);
                w_state_nxt    = ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (r_rd_cnt != 4'd0) begin
            w_rd_cnt_nxt = r_rd_cnt - 4'd1;
            if (r_rd_cnt == 4'd1) begin
              w_shift_nxt   = rd_data;
              w_bit_cnt_nxt = '0;
              // After a master ACK, SCL is still high here, so the MSB waits for the next fall
              if (!r_wait_fall) w_sda_oe_nxt = ~rd_data[7];
            end
          end else if (w_scl_fall) begin
            if (r_wait_fall) begin
              w_wait_fall_nxt = 1'b0;
              w_sda_oe_nxt    = ~r_shift[7];
            end else if (r_bit_cnt == LAST_BIT) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_RD_ACK;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
              w_sda_oe_nxt  = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_lvl == NACK) begin
              w_state_nxt = ST_IGNORE;
            end else begin
              w_reg_addr_nxt  = ptr_inc(r_reg_addr, addr_mode);
              w_rd_req_nxt    = 1'b1;
              w_rd_cnt_nxt    = RD_CNT_LOAD;
              w_wait_fall_nxt = 1'b1;
              w_state_nxt     = ST_RD_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
